// File: rtl/xsim_dma_pkg.sv
// rtl/xsim_dma_pkg.sv - shared types and constants for the xsim DMA burst initiator
package xsim_dma_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_WRITE  = 2'd2,
    ST_FINISH = 2'd3
  } dma_state_e;

  // beats is carried at full word width; the initiator truncates to LEN_W
  typedef struct packed {
    logic        write;
    logic [31:0] handle;
    logic [31:0] addr;
    logic [31:0] beats;
  } dma_cmd_t;

endpackage

// File: rtl/xsim_dma_resp_fifo.sv
// rtl/xsim_dma_resp_fifo.sv - read-response FIFO, DEPTH x (32-bit word + last flag)
module xsim_dma_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [31:0]      push_data,
  input  logic             push_last,
  input  logic             pop,
  output logic [31:0]      pop_data,
  output logic             pop_last,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [32:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign {pop_last, pop_data} = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_ptr] <= {push_last, push_data};
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/xsim_dma_burst_initiator.sv
// rtl/xsim_dma_burst_initiator.sv - splits burst commands into xsim DMA word transactions
// Optional perf counters are enabled by defining XSIM_DMA_PERF_CNT_EN.
module xsim_dma_burst_initiator
  import xsim_dma_pkg::*;
#(
  parameter int LEN_W       = 16,
  parameter int RFIFO_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_handle,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_beats,
  input  logic             wdata_valid,
  output logic             wdata_ready,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wdata_be,
  output logic             rdata_valid,
  input  logic             rdata_ready,
  output logic [31:0]      rdata,
  output logic             rdata_last,
  output logic             done,
  input  logic             rdy_readrequest,
  output logic             en_readrequest,
  output logic [31:0]      readrequest_addr,
  output logic [31:0]      readrequest_handle,
  input  logic             rdy_readresponse,
  output logic             en_readresponse,
  input  logic [31:0]      readresponse_data,
  output logic             en_write32,
  output logic [31:0]      write32_addr,
  output logic [31:0]      write32_handle,
  output logic [31:0]      write32_data,
  output logic [3:0]       write32_byteenable
`ifdef XSIM_DMA_PERF_CNT_EN
  ,
  output logic [31:0]      perf_busy_cycles,
  output logic [31:0]      perf_stall_cycles
`endif
);

  localparam int CNT_W = $clog2(RFIFO_DEPTH) + 1;

  dma_state_e       state;
  dma_state_e       state_n;
  dma_cmd_t         cmd_in;
  logic [31:0]      addr_q;
  logic [31:0]      handle_q;
  logic [LEN_W-1:0] req_left;
  logic [LEN_W-1:0] rsp_left;
  logic [LEN_W-1:0] cmd_len;
  logic             inflight;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             fifo_last_in;
  logic             room;
  logic             accept;

  assign cmd_in  = '{write: cmd_write, handle: cmd_handle, addr: cmd_addr, beats: 32'(cmd_beats)};
  assign cmd_len = LEN_W'(cmd_in.beats);
  assign accept  = cmd_ready && cmd_valid;

  // The outstanding request reserves a FIFO slot so its response can always land.
  assign room = ({1'b0, fifo_count} + (CNT_W+1)'(inflight)) < (CNT_W+1)'(RFIFO_DEPTH);

  // Words still owed to the client minus those already buffered picks out the final word.
  assign fifo_last_in = (rsp_left - LEN_W'(fifo_count)) == LEN_W'(1);

  assign rdata_valid = !fifo_empty;
  assign fifo_pop    = rdata_valid && rdata_ready;

  assign readrequest_addr   = addr_q;
  assign readrequest_handle = handle_q;
  assign write32_addr       = addr_q;
  assign write32_handle     = handle_q;
  assign write32_data       = wdata;
  assign write32_byteenable = wdata_be;

  xsim_dma_resp_fifo #(
    .DEPTH (RFIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_resp_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (en_readresponse),
    .push_data (readresponse_data),
    .push_last (fifo_last_in),
    .pop       (fifo_pop),
    .pop_data  (rdata),
    .pop_last  (rdata_last),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_n         = state;
    cmd_ready       = 1'b0;
    wdata_ready     = 1'b0;
    en_readrequest  = 1'b0;
    en_readresponse = 1'b0;
    en_write32      = 1'b0;
    done            = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = RST;
        if (cmd_valid && RST) begin
          if (cmd_len == '0) begin
            state_n = ST_FINISH;
          end else if (cmd_in.write) begin
            state_n = ST_WRITE;
          end else begin
            state_n = ST_READ;
          end
        end
      end
      ST_READ: begin
        en_readrequest  = (req_left != '0) && rdy_readrequest && room;
        en_readresponse = rdy_readresponse && !fifo_full;
        if (fifo_pop && (rsp_left == LEN_W'(1))) begin
          state_n = ST_FINISH;
        end
      end
      ST_WRITE: begin
        wdata_ready = 1'b1;
        en_write32  = wdata_valid;
        if (wdata_valid && (req_left == LEN_W'(1))) begin
          state_n = ST_FINISH;
        end
      end
      ST_FINISH: begin
        done    = 1'b1;
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      handle_q <= '0;
      req_left <= '0;
      rsp_left <= '0;
      inflight <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr_q   <= cmd_in.addr;
        handle_q <= cmd_in.handle;
        req_left <= cmd_len;
        rsp_left <= cmd_len;
      end else if (en_readrequest || en_write32) begin
        addr_q   <= addr_q + 32'(WORD_BYTES);
        req_left <= req_left - LEN_W'(1);
      end
      if (fifo_pop) begin
        rsp_left <= rsp_left - LEN_W'(1);
      end
      if (en_readrequest) begin
        inflight <= 1'b1;
      end else if (en_readresponse) begin
        inflight <= 1'b0;
      end
    end
  end

`ifdef XSIM_DMA_PERF_CNT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if ((state != ST_IDLE) && (perf_busy_cycles != '1)) begin
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      end
      if ((state == ST_READ) && (req_left != '0) && !en_readrequest &&
          (perf_stall_cycles != '1)) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_xsim_dma_burst_initiator.sv
// tb/tb_xsim_dma_burst_initiator.sv - randomized bench for xsim_dma_burst_initiator
module tb_xsim_dma_burst_initiator;

  localparam int LEN_W = 16;
  localparam int DEPTH = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_write = 1'b0;
  logic [31:0]      cmd_handle = '0;
  logic [31:0]      cmd_addr = '0;
  logic [LEN_W-1:0] cmd_beats = '0;
  logic             wdata_valid = 1'b0;
  logic             wdata_ready;
  logic [31:0]      wdata = '0;
  logic [3:0]       wdata_be = '0;
  logic             rdata_valid;
  logic             rdata_ready = 1'b0;
  logic [31:0]      rdata;
  logic             rdata_last;
  logic             done;
  logic             rdy_readrequest = 1'b0;
  logic             en_readrequest;
  logic [31:0]      readrequest_addr;
  logic [31:0]      readrequest_handle;
  logic             rdy_readresponse = 1'b0;
  logic             en_readresponse;
  logic [31:0]      readresponse_data = '0;
  logic             en_write32;
  logic [31:0]      write32_addr;
  logic [31:0]      write32_handle;
  logic [31:0]      write32_data;
  logic [3:0]       write32_byteenable;
`ifdef XSIM_DMA_PERF_CNT_EN
  logic [31:0]      perf_busy_cycles;
  logic [31:0]      perf_stall_cycles;
`endif

  always #5 CLK = ~CLK;

  xsim_dma_burst_initiator #(.LEN_W(LEN_W), .RFIFO_DEPTH(DEPTH)) dut (
    .CLK                (CLK),
    .RST                (RST),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_write          (cmd_write),
    .cmd_handle         (cmd_handle),
    .cmd_addr           (cmd_addr),
    .cmd_beats          (cmd_beats),
    .wdata_valid        (wdata_valid),
    .wdata_ready        (wdata_ready),
    .wdata              (wdata),
    .wdata_be           (wdata_be),
    .rdata_valid        (rdata_valid),
    .rdata_ready        (rdata_ready),
    .rdata              (rdata),
    .rdata_last         (rdata_last),
    .done               (done),
    .rdy_readrequest    (rdy_readrequest),
    .en_readrequest     (en_readrequest),
    .readrequest_addr   (readrequest_addr),
    .readrequest_handle (readrequest_handle),
    .rdy_readresponse   (rdy_readresponse),
    .en_readresponse    (en_readresponse),
    .readresponse_data  (readresponse_data),
    .en_write32         (en_write32),
    .write32_addr       (write32_addr),
    .write32_handle     (write32_handle),
    .write32_data       (write32_data),
    .write32_byteenable (write32_byteenable)
`ifdef XSIM_DMA_PERF_CNT_EN
    ,
    .perf_busy_cycles   (perf_busy_cycles),
    .perf_stall_cycles  (perf_stall_cycles)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [31:0] ep_q[$];

  bit          cur_write;
  logic [31:0] base;
  logic [31:0] hdl;
  int          nb;
  int req_cnt, rd_cnt, wr_cnt, done_cnt, bad_hs;
  int first_req, first_rv, last_rv, last_wr, done_cyc, acc_cyc;
  bit accepted, pend_cmd, drop_cmd;
  int rr_pct = 100;
  int rdr_pct = 100;
  int wv_pct = 100;
  bit wv_toggle = 1'b0;
  bit tog = 1'b1;
  bit be_rand = 1'b0;
  int hold_until = 0;
  int snap_at = -1;
  int snap_req, snap_rd, snap_rv;

  // Endpoint memory contents: a fixed scramble of handle and address.
  function automatic logic [31:0] mem_word(input logic [31:0] h, input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ h ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctrl"}, 32'({cmd_ready, wdata_ready, rdata_valid, done,
                             en_readrequest, en_readresponse, en_write32}), 32'd0);
    chk({tag, "_raddr"}, readrequest_addr, 32'd0);
    chk({tag, "_rhandle"}, readrequest_handle, 32'd0);
    chk({tag, "_waddr"}, write32_addr, 32'd0);
  endtask

  // One clock: drive at the falling edge, then observe what the next rising edge commits.
  task automatic step();
    @(negedge CLK);
    cyc++;
    if (drop_cmd) begin
      cmd_valid = 1'b0;
      drop_cmd  = 1'b0;
    end
    if (pend_cmd) begin
      cmd_valid  = 1'b1;
      cmd_write  = cur_write;
      cmd_handle = hdl;
      cmd_addr   = base;
      cmd_beats  = LEN_W'(nb);
      pend_cmd   = 1'b0;
    end
    rdy_readrequest   = (int'($urandom_range(99)) < rr_pct);
    rdy_readresponse  = (ep_q.size() != 0);
    readresponse_data = (ep_q.size() != 0) ? ep_q[0] : 32'hDEAD_BEEF;
    rdata_ready       = (cyc >= hold_until) && (int'($urandom_range(99)) < rdr_pct);
    wdata             = $urandom();
    wdata_be          = be_rand ? 4'($urandom()) : 4'hF;
    if (!cur_write) begin
      wdata_valid = 1'b0;
    end else if (wv_toggle) begin
      if (wdata_ready) begin
        wdata_valid = tog;
        tog = !tog;
      end else begin
        wdata_valid = 1'b0;
      end
    end else begin
      wdata_valid = (int'($urandom_range(99)) < wv_pct);
    end
    #1;
    if (cmd_valid && cmd_ready) begin
      accepted = 1'b1;
      acc_cyc  = cyc;
      drop_cmd = 1'b1;
    end
    if (en_readresponse) begin
      if (ep_q.size() == 0) bad_hs++;
      else void'(ep_q.pop_front());
    end
    if (en_readrequest) begin
      if (!rdy_readrequest) bad_hs++;
      chk("rreq_addr", readrequest_addr, base + 32'(4 * req_cnt));
      chk("rreq_handle", readrequest_handle, hdl);
      ep_q.push_back(mem_word(readrequest_handle, readrequest_addr));
      if (first_req < 0) first_req = cyc;
      req_cnt++;
    end
    if (rdata_valid && first_rv < 0) first_rv = cyc;
    if (rdata_valid && rdata_ready) begin
      chk("rdata", rdata, mem_word(hdl, base + 32'(4 * rd_cnt)));
      chk("rdata_last", 32'(rdata_last), 32'(rd_cnt == nb - 1));
      last_rv = cyc;
      rd_cnt++;
    end
    if (en_write32 !== (wdata_ready && wdata_valid)) bad_hs++;
    if (en_write32) begin
      chk("wr_addr", write32_addr, base + 32'(4 * wr_cnt));
      chk("wr_handle", write32_handle, hdl);
      chk("wr_data", write32_data, wdata);
      chk("wr_be", 32'(write32_byteenable), 32'(wdata_be));
      last_wr = cyc;
      wr_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (cyc == snap_at) begin
      snap_req = req_cnt;
      snap_rd  = rd_cnt;
      snap_rv  = int'(rdata_valid);
    end
  endtask

  task automatic run_burst(input bit w, input logic [31:0] h, input logic [31:0] a,
                           input int n, input int abort_rd);
    cur_write = w;
    hdl       = h;
    base      = a;
    nb        = n;
    req_cnt   = 0;
    rd_cnt    = 0;
    wr_cnt    = 0;
    done_cnt  = 0;
    bad_hs    = 0;
    first_req = -1;
    first_rv  = -1;
    last_rv   = -1;
    last_wr   = -1;
    done_cyc  = -1;
    acc_cyc   = -1;
    accepted  = 1'b0;
    tog       = 1'b1;
    pend_cmd  = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (abort_rd >= 0 && rd_cnt >= abort_rd) return;
      if (done_cnt != 0) break;
    end
    repeat (3) step();
    chk("accepted", 32'(accepted), 32'd1);
    chk("done_pulses", done_cnt, 1);
    if (w) chk("write_beats", wr_cnt, n);
    else begin
      chk("read_requests", req_cnt, n);
      chk("read_words", rd_cnt, n);
    end
    chk("other_dir_quiet", w ? (req_cnt + rd_cnt) : wr_cnt, 0);
    chk("handshake_rules", bad_hs, 0);
    chk("endpoint_drained", ep_q.size(), 0);
    chk("back_to_idle", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    #1;
    chk_reset("por");
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);

    // Basic read: latency and full-rate streaming.
    run_burst(1'b0, 32'd5, 32'h0000_0100, 4, -1);
    chk("rd_latency", first_rv - first_req, 2);
    chk("rd_throughput", last_rv - first_rv, 3);
    chk("rd_done_after_last", done_cyc - last_rv, 1);
`ifdef XSIM_DMA_PERF_CNT_EN
    chk("perf_busy_nonzero", 32'(perf_busy_cycles != 0), 32'd1);
`endif

    // Write that wraps the 32-bit address space.
    run_burst(1'b1, 32'h77, 32'hFFFF_FFF8, 3, -1);
    chk("wr_done_after_last", done_cyc - last_wr, 1);

    // Client stalls: FIFO fills, requests stop, everything drains afterwards.
    hold_until = cyc + 21;
    snap_at    = cyc + 20;
    run_burst(1'b0, 32'd9, 32'h0000_2000, 8, -1);
    chk("stall_requests", snap_req, DEPTH);
    chk("stall_no_pops", snap_rd, 0);
    chk("stall_head_valid", snap_rv, 1);
    snap_at = -1;

    // Zero-length bursts in both directions.
    run_burst(1'b0, 32'd1, 32'h0000_0040, 0, -1);
    chk("zero_rd_done_lat", 32'((done_cyc - acc_cyc) inside {[1:2]}), 32'd1);
    run_burst(1'b1, 32'd2, 32'h0000_0080, 0, -1);
    chk("zero_wr_done_lat", 32'((done_cyc - acc_cyc) inside {[1:2]}), 32'd1);

    // Reset in the middle of a read, then a fresh single-word read.
    run_burst(1'b0, 32'd3, 32'h0000_0400, 6, 2);
    @(negedge CLK);
    RST = 1'b0;
    ep_q.delete();
    rdy_readresponse = 1'b0;
    cmd_valid = 1'b0;
    drop_cmd  = 1'b0;
    #1;
    chk_reset("mid_burst");
    @(negedge CLK);
    RST = 1'b1;
    run_burst(1'b0, 32'h11, 32'h0000_0800, 1, -1);

    // Write with gaps in the client stream.
    wv_toggle = 1'b1;
    run_burst(1'b1, 32'h42, 32'h0000_3000, 2, -1);
    wv_toggle = 1'b0;

    // Randomized commands and flow control.
    be_rand = 1'b1;
    for (int k = 0; k < 14; k++) begin
      rr_pct  = int'($urandom_range(100, 30));
      rdr_pct = int'($urandom_range(100, 30));
      wv_pct  = int'($urandom_range(100, 30));
      run_burst(1'($urandom_range(1)), $urandom(), $urandom() & 32'hFFFF_FFFC,
                int'($urandom_range(12)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
